// File: rtl/cycle_ctl.sv
// Processor cycle controller: START/WAIT/CYCLE flags and KC->PC sequencing.
// Ports: __clk, clm_ (sync clear); panel/sequencer pulses in; phase and cycle-select flags out.
module cycle_ctl #(
    parameter int KC_TICKS = 3,
    parameter int PC_TICKS = 2,
    parameter int IRQ_CH   = 4,
    parameter int IRQ_W    = 2
) (
    input  logic              __clk,
    input  logic              clm_,
    input  logic              start_req,
    input  logic              stop_req,
    input  logic              cycle_req,
    input  logic              hlt_wx,
    input  logic              ekc,
    input  logic [IRQ_CH-1:0] irq,
    input  logic [IRQ_CH-1:0] irq_mask,
    input  logic              p_,
    input  logic              mc_,
    output logic              start,
    output logic              wait_,
    output logic              run,
    output logic              kc,
    output logic              pc,
    output logic              pr,
    output logic              przerw,
    output logic [IRQ_W-1:0]  irq_num,
    output logic              sp0,
    output logic              sp1,
    output logic              si1,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_KC,
        S_PC,
        S_EXEC
    } state_t;

    localparam logic [7:0] KC_LAST = 8'(KC_TICKS - 1);
    localparam logic [7:0] PC_LAST = 8'(PC_TICKS - 1);

    state_t            state;
    logic [7:0]        cnt;
    logic              start_q;
    logic              wait_q;
    logic              cyc_q;
    logic              pr_q;
    logic              przerw_q;
    logic [IRQ_W-1:0]  irq_num_q;

    logic [IRQ_CH-1:0] req_v;
    logic              irq_ok;
    logic              kc_last;
    logic              pc_last;

    // Lowest-numbered eligible channel wins.
    function automatic logic [IRQ_W-1:0] lowest(input logic [IRQ_CH-1:0] v);
        lowest = '0;
        for (int i = IRQ_CH - 1; i >= 0; i--) begin
            if (v[i]) lowest = IRQ_W'(i);
        end
    endfunction

    assign req_v   = irq & irq_mask;
    assign irq_ok  = (|req_v) & p_ & mc_ & (start_q | cyc_q);
    assign kc_last = (state == S_KC) && (cnt == KC_LAST);
    assign pc_last = (state == S_PC) && (cnt == PC_LAST);

    assign start   = start_q;
    assign wait_   = ~wait_q;
    assign run     = start_q & ~wait_q;
    assign kc      = (state == S_KC);
    assign pc      = (state == S_PC);
    assign pr      = pr_q;
    assign przerw  = przerw_q;
    assign irq_num = irq_num_q;
    assign sp0     = pc & ~pr_q & ~przerw_q;
    assign sp1     = pc & pr_q;
    assign si1     = pc & przerw_q;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge __clk) begin
        if (!clm_) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            start_q   <= 1'b0;
            wait_q    <= 1'b0;
            cyc_q     <= 1'b0;
            pr_q      <= 1'b0;
            przerw_q  <= 1'b0;
            irq_num_q <= '0;
        end else begin
            if (stop_req)       start_q <= 1'b0;
            else if (start_req) start_q <= 1'b1;

            if (stop_req || si1) wait_q <= 1'b0;
            else if (hlt_wx)     wait_q <= 1'b1;

            // A step request arriving on the last KC clock survives the clear.
            cyc_q <= cycle_req | (cyc_q & ~kc_last);

            unique case (state)
                S_IDLE: begin
                    if (run || cyc_q || (start_q && irq_ok)) begin
                        state <= S_KC;
                        cnt   <= 8'd0;
                    end
                end
                S_KC: begin
                    if (kc_last) begin
                        przerw_q <= irq_ok;
                        pr_q     <= ~irq_ok & (run | cyc_q);
                        if (irq_ok) irq_num_q <= lowest(req_v);
                        state <= S_PC;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_PC: begin
                    if (pc_last) begin
                        state <= (pr_q || przerw_q) ? S_EXEC : S_IDLE;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    if (ekc) begin
                        state <= S_KC;
                        cnt   <= 8'd0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cycle_ctl.sv
// Directed bench for cycle_ctl: default-parameter vector table plus
// a hand-written sequence on a 1/1/1 parameter corner instance.
module tb_cycle_ctl;

    logic clk;
    int   checks;
    int   failures;

    logic       clm_, start_req, stop_req, cycle_req, hlt_wx, ekc, p_, mc_;
    logic [3:0] irq, irq_mask;
    logic       start, wait_, run, kc, pc, pr, przerw, sp0, sp1, si1, busy;
    logic [1:0] irq_num;

    logic       c2_clm, c2_start_req, c2_ekc;
    logic [0:0] c2_irq, c2_mask;
    logic       s2, w2, r2, k2, pc2, pr2, pz2, sp0_2, sp1_2, si1_2, b2;
    logic [0:0] n2;

    cycle_ctl dut (
        .__clk(clk), .clm_(clm_), .start_req(start_req),
        .stop_req(stop_req), .cycle_req(cycle_req), .hlt_wx(hlt_wx),
        .ekc(ekc), .irq(irq), .irq_mask(irq_mask), .p_(p_), .mc_(mc_),
        .start(start), .wait_(wait_), .run(run), .kc(kc), .pc(pc),
        .pr(pr), .przerw(przerw), .irq_num(irq_num), .sp0(sp0),
        .sp1(sp1), .si1(si1), .busy(busy)
    );

    cycle_ctl #(.KC_TICKS(1), .PC_TICKS(1), .IRQ_CH(1), .IRQ_W(1)) dut2 (
        .__clk(clk), .clm_(c2_clm), .start_req(c2_start_req),
        .stop_req(1'b0), .cycle_req(1'b0), .hlt_wx(1'b0),
        .ekc(c2_ekc), .irq(c2_irq), .irq_mask(c2_mask), .p_(1'b1),
        .mc_(1'b1), .start(s2), .wait_(w2), .run(r2), .kc(k2), .pc(pc2),
        .pr(pr2), .przerw(pz2), .irq_num(n2), .sp0(sp0_2),
        .sp1(sp1_2), .si1(si1_2), .busy(b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr, st, sp, cy, hlt, ek;
        logic [3:0]  irq, msk;
        logic        p, mc;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Expected order: start wait_ run kc pc pr przerw irq_num sp0 sp1 si1 busy
    task automatic add(input logic clr, st, sp, cy, hlt, ek,
                       input logic [3:0] iq, mk, input logic p, mc,
                       input logic s, w, b, k, ph, r, z,
                       input logic [1:0] n);
        vec_t v;
        v.clr = clr; v.st = st; v.sp = sp; v.cy = cy;
        v.hlt = hlt; v.ek = ek; v.irq = iq; v.msk = mk;
        v.p = p; v.mc = mc;
        v.exp = {s, w, s & w, k, ph, r, z, n,
                 ph & ~r & ~z, ph & r, ph & z, b};
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        clm_ = 0; start_req = 0; stop_req = 0; cycle_req = 0;
        hlt_wx = 0; ekc = 0; irq = 0; irq_mask = 0; p_ = 1; mc_ = 1;
        c2_clm = 0; c2_start_req = 0; c2_ekc = 0; c2_irq = 0; c2_mask = 0;

        //  clr st sp cy hl ek irq    msk   p mc   S W B K P pr pz n
        add(0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,0,0,0,0,0,0); // reset
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,0,0,0,0,0,0);
        add(1, 1, 1, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,0,0,0,0,0,0); // start+stop
        add(1, 1, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  1,1,0,0,0,0,0,0);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  1,1,1,1,0,0,0,0); // KC x3
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  1,1,1,1,0,0,0,0);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  1,1,1,1,0,0,0,0);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  1,1,1,0,1,1,0,0); // PC fetch
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  1,1,1,0,1,1,0,0);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  1,1,1,0,0,1,0,0); // EXEC
        add(1, 0, 0, 0, 1, 0, 4'h0, 4'h0, 1, 1,  1,0,1,0,0,1,0,0); // halt
        add(1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 1, 1,  1,0,1,1,0,1,0,0);
        add(1, 0, 0, 0, 0, 0, 4'h6, 4'hF, 1, 1,  1,0,1,1,0,1,0,0);
        add(1, 0, 0, 0, 0, 0, 4'h6, 4'hF, 1, 1,  1,0,1,1,0,1,0,0);
        add(1, 0, 0, 0, 0, 0, 4'h6, 4'hF, 1, 1,  1,0,1,0,1,0,1,1); // irq 1
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'hF, 1, 1,  1,1,1,0,1,0,1,1); // si1 clr
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  1,1,1,0,0,0,1,1);
        add(1, 0, 0, 0, 0, 1, 4'h8, 4'h7, 1, 1,  1,1,1,1,0,0,1,1); // masked
        add(1, 0, 0, 0, 0, 0, 4'h8, 4'h7, 1, 1,  1,1,1,1,0,0,1,1);
        add(1, 0, 0, 0, 0, 0, 4'h8, 4'h7, 1, 1,  1,1,1,1,0,0,1,1);
        add(1, 0, 0, 0, 0, 0, 4'h8, 4'h7, 1, 1,  1,1,1,0,1,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  1,1,1,0,1,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  1,1,1,0,0,1,0,1);
        add(1, 0, 0, 0, 0, 1, 4'h8, 4'hF, 1, 0,  1,1,1,1,0,1,0,1); // mc_=0
        add(1, 0, 0, 0, 0, 0, 4'h8, 4'hF, 1, 0,  1,1,1,1,0,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h8, 4'hF, 1, 0,  1,1,1,1,0,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h8, 4'hF, 1, 0,  1,1,1,0,1,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  1,1,1,0,1,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  1,1,1,0,0,1,0,1);
        add(1, 0, 1, 0, 0, 1, 4'h0, 4'h0, 1, 1,  0,1,1,1,0,1,0,1); // stop
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,1,0,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,1,0,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,0,1,0,0,1); // sp0
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,0,1,0,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,0,0,0,0,0,1); // IDLE
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,0,0,0,0,0,1);
        add(1, 0, 0, 1, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,0,0,0,0,0,1); // step
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,1,0,0,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,1,0,0,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,1,0,0,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,0,1,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,0,1,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,0,0,1,0,1);
        add(1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 1, 1,  0,1,1,1,0,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,1,0,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,1,0,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,0,1,0,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,0,1,0,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,0,0,0,0,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,0,0,0,0,0,1);
        add(1, 0, 0, 1, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,0,0,0,0,0,1); // step 2
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,1,0,0,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,1,0,0,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,1,0,0,0,1);
        add(1, 0, 0, 1, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,0,1,1,0,1); // coincide
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,0,1,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,0,0,1,0,1);
        add(1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 1, 1,  0,1,1,1,0,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,1,0,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,1,0,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,0,1,1,0,1); // kept
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,0,1,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,0,0,1,0,1);
        add(1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 1, 1,  0,1,1,1,0,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,1,0,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,1,0,1,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,0,1,0,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,1,0,1,0,0,1);
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,0,0,0,0,0,1);
        add(1, 1, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  1,1,0,0,0,0,0,1); // start
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  1,1,1,1,0,0,0,1); // KC 1
        add(1, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  1,1,1,1,0,0,0,1); // KC 2
        add(0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 1,  0,1,0,0,0,0,0,0); // clear

        for (int i = 0; i < tbl.size(); i++) begin
            clm_ = tbl[i].clr; start_req = tbl[i].st;
            stop_req = tbl[i].sp; cycle_req = tbl[i].cy;
            hlt_wx = tbl[i].hlt; ekc = tbl[i].ek;
            irq = tbl[i].irq; irq_mask = tbl[i].msk;
            p_ = tbl[i].p; mc_ = tbl[i].mc;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                {3'b0, start, wait_, run, kc, pc, pr, przerw, irq_num,
                 sp0, sp1, si1, busy},
                {3'b0, tbl[i].exp});
        end
        clm_ = 1; start_req = 0; stop_req = 0; cycle_req = 0;
        hlt_wx = 0; ekc = 0; irq = 0; irq_mask = 0; p_ = 1; mc_ = 1;

        // 1/1/1 corner: one-clock phases, irq_num pinned to 0
        @(posedge clk); #1;
        chk("c2_reset", {4'b0, s2, w2, r2, k2, pc2, pr2, pz2, n2,
            sp0_2, sp1_2, si1_2, b2}, 16'b0000_010000000000);
        c2_clm = 1; c2_start_req = 1;
        @(posedge clk); #1;
        chk("c2_start", {4'b0, s2, w2, r2, k2, pc2, pr2, pz2, n2,
            sp0_2, sp1_2, si1_2, b2}, 16'b0000_111000000000);
        c2_start_req = 0;
        @(posedge clk); #1;
        chk("c2_kc", {4'b0, s2, w2, r2, k2, pc2, pr2, pz2, n2,
            sp0_2, sp1_2, si1_2, b2}, 16'b0000_111100000001);
        @(posedge clk); #1;
        chk("c2_pc", {4'b0, s2, w2, r2, k2, pc2, pr2, pz2, n2,
            sp0_2, sp1_2, si1_2, b2}, 16'b0000_111011000101);
        @(posedge clk); #1;
        chk("c2_exec", {4'b0, s2, w2, r2, k2, pc2, pr2, pz2, n2,
            sp0_2, sp1_2, si1_2, b2}, 16'b0000_111001000001);
        c2_ekc = 1; c2_irq = 1'b1; c2_mask = 1'b1;
        @(posedge clk); #1;
        chk("c2_kc2", {4'b0, s2, w2, r2, k2, pc2, pr2, pz2, n2,
            sp0_2, sp1_2, si1_2, b2}, 16'b0000_111101000001);
        c2_ekc = 0;
        @(posedge clk); #1;
        chk("c2_irq", {4'b0, s2, w2, r2, k2, pc2, pr2, pz2, n2,
            sp0_2, sp1_2, si1_2, b2}, 16'b0000_111010100011);
        c2_irq = 1'b0;
        @(posedge clk); #1;
        chk("c2_exec2", {4'b0, s2, w2, r2, k2, pc2, pr2, pz2, n2,
            sp0_2, sp1_2, si1_2, b2}, 16'b0000_111000100001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
